// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// A synchronous flush discards all held beats and counts them, saturating.
module pipe_stage_skid #(
    parameter int unsigned          DW         = 32,
    parameter logic [DW-1:0]        BUBBLE_VAL = '0,
    parameter int unsigned          CW         = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    input  logic          flush_i,
    output logic [1:0]    occupancy_o,
    output logic [CW-1:0] flush_cnt_o
);

    // The state encoding is the occupancy itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   main_q, main_d;
    logic [DW-1:0]   skid_q, skid_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic [CW-1:0]   flush_cnt_q, flush_cnt_d;

    logic            accept;
    logic            take;
    logic [1:0]      discard;
    logic [CW+1:0]   cnt_sum;

    localparam logic [CW+1:0] CNT_MAX = {2'b00, {CW{1'b1}}};

    assign accept = in_valid_i & in_ready_q;
    assign take   = out_valid_q & out_ready_i;

    // Beats lost to a flush: held beats not taken, plus the beat accepted this cycle.
    assign discard = 2'(state_q) - 2'(take) + 2'(accept);
    assign cnt_sum = {2'b00, flush_cnt_q} + (CW+2)'(discard);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        flush_cnt_d = flush_cnt_q;

        if (flush_i) begin
            state_d     = EMPTY;
            main_d      = BUBBLE_VAL;
            flush_cnt_d = (cnt_sum > CNT_MAX) ? CNT_MAX[CW-1:0] : cnt_sum[CW-1:0];
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_data_i;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        main_d = in_data_i;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_data_i;
                    end else if (take) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
                end
                FULL: begin
                    if (take) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_VAL;
                end
            endcase
        end

        // Handshake outputs are computed from the next state so they leave the stage as flops.
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            flush_cnt_q <= '0;
            main_q      <= BUBBLE_VAL;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            flush_cnt_q <= flush_cnt_d;
            main_q      <= main_d;
        end
    end

    // NOTE: the skid payload needs no reset; it is only read after being written in FULL.
    always_ff @(posedge clk_i) begin
        skid_q <= skid_d;
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;
    assign occupancy_o = state_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, backpressure, flush counting, async reset.
module tb_pipe_stage_skid;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic [31:0] in_data_i;
    logic        out_ready_i;
    logic        flush_i;

    logic        in_ready_o, out_valid_o;
    logic [31:0] out_data_o;
    logic [1:0]  occupancy_o;
    logic [7:0]  flush_cnt_o;

    logic        in_ready2, out_valid2;
    logic [31:0] out_data2;
    logic [1:0]  occupancy2;
    logic [1:0]  flush_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    pipe_stage_skid #(.DW(32), .BUBBLE_VAL(NOP), .CW(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .flush_i(flush_i), .occupancy_o(occupancy_o), .flush_cnt_o(flush_cnt_o)
    );

    pipe_stage_skid #(.DW(32), .CW(2)) dut_cw2 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready2), .in_data_i(in_data_i),
        .out_valid_o(out_valid2), .out_ready_i(out_ready_i), .out_data_o(out_data2),
        .flush_i(flush_i), .occupancy_o(occupancy2), .flush_cnt_o(flush_cnt2)
    );

    // Advance one rising edge and settle; inputs change and outputs are sampled here.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_state(input string name, input logic v, input logic [31:0] d,
                                input logic [1:0] occ, input logic rdy);
        checks++;
        if (out_valid_o !== v || out_data_o !== d || occupancy_o !== occ || in_ready_o !== rdy) begin
            errors++;
            $display("FAIL %s: got valid=%0b data=%h occ=%0d ready=%0b, want valid=%0b data=%h occ=%0d ready=%0b",
                     name, out_valid_o, out_data_o, occupancy_o, in_ready_o, v, d, occ, rdy);
        end
    endtask

    task automatic expect_cnt(input string name, input logic [7:0] c8, input logic [1:0] c2);
        checks++;
        if (flush_cnt_o !== c8 || flush_cnt2 !== c2) begin
            errors++;
            $display("FAIL %s: got cnt=%0d cnt_cw2=%0d, want cnt=%0d cnt_cw2=%0d",
                     name, flush_cnt_o, flush_cnt2, c8, c2);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0; flush_i = 1'b0;
        #12;
        expect_state("reset_state", 1'b0, NOP, 2'd0, 1'b1);
        expect_cnt("reset_cnt", 8'd0, 2'd0);
        rst_ni = 1'b1;
        cyc();
        expect_state("reset_idle", 1'b0, NOP, 2'd0, 1'b1);
    endtask

    task automatic test_stream();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1; in_data_i = vals[i];
            cyc();
            expect_state($sformatf("stream_%0d", i), 1'b1, vals[i], 2'd1, 1'b1);
        end
        in_valid_i = 1'b0;
        cyc();
        expect_state("stream_drain", 1'b0, NOP, 2'd0, 1'b1);
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'hA;
        cyc();
        expect_state("bp_one", 1'b1, 32'hA, 2'd1, 1'b1);
        in_data_i = 32'hB;
        cyc();
        expect_state("bp_full", 1'b1, 32'hA, 2'd2, 1'b0);
        in_data_i = 32'hC;
        cyc();
        expect_state("bp_hold", 1'b1, 32'hA, 2'd2, 1'b0);
        out_ready_i = 1'b1;
        cyc();
        expect_state("bp_out_b", 1'b1, 32'hB, 2'd1, 1'b1);
        cyc();
        expect_state("bp_out_c", 1'b1, 32'hC, 2'd1, 1'b1);
        in_valid_i = 1'b0;
        cyc();
        expect_state("bp_drain", 1'b0, NOP, 2'd0, 1'b1);
    endtask

    task automatic test_flush_full();
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'hA;
        cyc();
        in_data_i = 32'hB;
        cyc();
        expect_state("flf_full", 1'b1, 32'hA, 2'd2, 1'b0);
        in_valid_i = 1'b0; flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        expect_state("flf_empty", 1'b0, NOP, 2'd0, 1'b1);
        expect_cnt("flf_cnt", 8'd2, 2'd2);
    endtask

    task automatic test_flush_take();
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'h5;
        cyc();
        expect_state("flt_one", 1'b1, 32'h5, 2'd1, 1'b1);
        in_data_i = 32'h6; out_ready_i = 1'b1; flush_i = 1'b1;
        cyc();
        flush_i = 1'b0; in_valid_i = 1'b0;
        expect_state("flt_empty", 1'b0, NOP, 2'd0, 1'b1);
        expect_cnt("flt_cnt", 8'd3, 2'd3);
        cyc();
        expect_state("flt_no_ghost", 1'b0, NOP, 2'd0, 1'b1);
    endtask

    task automatic test_saturate();
        logic [7:0] want8 [3];
        logic [1:0] want2 [3];
        want8[0] = 8'd2; want8[1] = 8'd4; want8[2] = 8'd6;
        want2[0] = 2'd2; want2[1] = 2'd3; want2[2] = 2'd3;
        rst_ni = 1'b0;
        #3;
        expect_cnt("sat_reset", 8'd0, 2'd0);
        rst_ni = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            out_ready_i = 1'b0;
            in_valid_i = 1'b1; in_data_i = 32'h100 + 32'(i);
            cyc();
            in_data_i = 32'h200 + 32'(i);
            cyc();
            in_valid_i = 1'b0; flush_i = 1'b1;
            cyc();
            flush_i = 1'b0;
            expect_cnt($sformatf("sat_%0d", i), want8[i], want2[i]);
        end
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'hD;
        cyc();
        in_data_i = 32'hE;
        cyc();
        expect_state("ar_full", 1'b1, 32'hD, 2'd2, 1'b0);
        in_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        expect_state("ar_immediate", 1'b0, NOP, 2'd0, 1'b1);
        expect_cnt("ar_cnt", 8'd0, 2'd0);
        out_ready_i = 1'b1;
        cyc();
        #2 rst_ni = 1'b1;
        cyc();
        expect_state("ar_no_stale_0", 1'b0, NOP, 2'd0, 1'b1);
        cyc();
        expect_state("ar_no_stale_1", 1'b0, NOP, 2'd0, 1'b1);
        in_valid_i = 1'b1; in_data_i = 32'h77;
        cyc();
        in_valid_i = 1'b0;
        expect_state("ar_new_beat", 1'b1, 32'h77, 2'd1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_flush_take();
        test_saturate();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
